// File: rtl/id_stage_pkg.sv
// Shared decode constants, PC-select encodings and small helpers for id_stage.
package id_stage_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned REG_AW    = $clog2(REG_COUNT);

  localparam logic [XLEN-1:0] NOP  = 32'h0000_0000;
  localparam logic [XLEN-1:0] HALT = 32'hffff_ffff;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [1:0] {
    PCS_PC4 = 2'b00,
    PCS_B   = 2'b01,
    PCS_JR  = 2'b10,
    PCS_J   = 2'b11
  } pcsrc_e;

  // True when a non-zero register is still being produced by EX or MEM.
  function automatic logic reg_pending(input logic [REG_AW-1:0] r,
                                       input logic              we_e,
                                       input logic [REG_AW-1:0] wr_e,
                                       input logic              we_m,
                                       input logic [REG_AW-1:0] wr_m);
    return (r != '0) && ((we_e && (wr_e == r)) || (we_m && (wr_m == r)));
  endfunction

  function automatic logic [XLEN-1:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/regfile_32x32.sv
// 32x32 register file: async clear, r0 hardwired to zero, write-through reads.
// Ports: clk, reset (async active-low); ra1/ra2 read addresses -> rd1/rd2;
//        we/wa/wd write port (posedge).
module regfile_32x32
  import id_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [XLEN-1:0]   wd,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2
);

  logic [XLEN-1:0] mem [REG_COUNT];
  logic            wr_en;

  assign wr_en = we && (wa != '0);

  // Storage; r0 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wa] <= wd;
    end
  end

  // Reads bypass the same-cycle writeback so decode never sees stale data.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = (wr_en && (wa == ra1)) ? wd : mem[ra1];
    if (ra2 != '0) rd2 = (wr_en && (wa == ra2)) ? wd : mem[ra2];
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, register file, load-use and branch-data
// hazard detection, and beq/bne/j/jr resolution back to fetch.
// Inputs : fetched instruction/PC+1/halt flag, EX/MEM destination info for
//          hazards, writeback port.
// Outputs: stall/bubble, PC select and targets, decoded fields and operands.
module id_stage
  import id_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   InstructionF,
  input  logic [XLEN-1:0]   PC4F,
  input  logic              StopF,
  input  logic              RegWriteE,
  input  logic              MemReadE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic [XLEN-1:0]   ResultW,
  output logic              isLWHazard,
  output logic [1:0]        PCSource,
  output logic [XLEN-1:0]   PC_B,
  output logic [XLEN-1:0]   aD,
  output logic [XLEN-1:0]   PC_J,
  output logic              BubbleD,
  output logic [XLEN-1:0]   RD1D,
  output logic [XLEN-1:0]   RD2D,
  output logic [XLEN-1:0]   ImmD,
  output logic [REG_AW-1:0] RsD,
  output logic [REG_AW-1:0] RtD,
  output logic [REG_AW-1:0] RdD,
  output logic [5:0]        OpD,
  output logic [5:0]        FunctD,
  output logic              StopD
);

  logic [XLEN-1:0] instr_d;
  logic [XLEN-1:0] pc4_d;
  logic            stop_d;
  logic            load_use;
  logic            branch_hz;
  logic            is_beq, is_bne, is_j, is_jr;
  logic            reads_rs, reads_rt;
  pcsrc_e          pc_sel;

  // IF/ID register: stall holds, redirect squashes, otherwise advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_d <= NOP;
      pc4_d   <= '0;
      stop_d  <= 1'b0;
    end else if (!isLWHazard) begin
      instr_d <= (pc_sel != PCS_PC4) ? NOP : InstructionF;
      pc4_d   <= PC4F;
      stop_d  <= stop_d | StopF;
    end
  end

  regfile_32x32 u_rf (
    .clk   (clk),
    .reset (reset),
    .ra1   (RsD),
    .ra2   (RtD),
    .we    (RegWriteW),
    .wa    (WriteRegW),
    .wd    (ResultW),
    .rd1   (RD1D),
    .rd2   (RD2D)
  );

  assign OpD    = instr_d[31:26];
  assign RsD    = instr_d[25:21];
  assign RtD    = instr_d[20:16];
  assign RdD    = instr_d[15:11];
  assign FunctD = instr_d[5:0];
  assign ImmD   = sign_ext16(instr_d[15:0]);
  assign StopD  = stop_d;

  assign is_beq = (OpD == OP_BEQ);
  assign is_bne = (OpD == OP_BNE);
  assign is_j   = (OpD == OP_J);
  assign is_jr  = (OpD == OP_RTYPE) && (FunctD == FN_JR);

  // Which source fields the decoded instruction actually consumes.
  assign reads_rs = !(is_j || (OpD == OP_JAL) || (instr_d == HALT));
  assign reads_rt = (OpD == OP_RTYPE) || is_beq || is_bne || (OpD == OP_SW);

  // Hazard detection and redirect; a stall suppresses any redirect.
  always_comb begin
    load_use  = 1'b0;
    branch_hz = 1'b0;
    pc_sel    = PCS_PC4;
    if (MemReadE && (WriteRegE != '0) &&
        ((reads_rs && (WriteRegE == RsD)) || (reads_rt && (WriteRegE == RtD))))
      load_use = 1'b1;
    if ((is_beq || is_bne || is_jr) &&
        reg_pending(RsD, RegWriteE, WriteRegE, RegWriteM, WriteRegM))
      branch_hz = 1'b1;
    if ((is_beq || is_bne) &&
        reg_pending(RtD, RegWriteE, WriteRegE, RegWriteM, WriteRegM))
      branch_hz = 1'b1;
    if (!load_use && !branch_hz && !stop_d) begin
      if ((is_beq && (RD1D == RD2D)) || (is_bne && (RD1D != RD2D))) pc_sel = PCS_B;
      else if (is_j)                                               pc_sel = PCS_J;
      else if (is_jr)                                              pc_sel = PCS_JR;
    end
  end

  assign isLWHazard = load_use | branch_hz;
  assign BubbleD    = isLWHazard;
  assign PCSource   = pc_sel;
  assign PC_B       = pc4_d + ImmD;
  assign PC_J       = {pc4_d[31:26], instr_d[25:0]};
  assign aD         = RD1D;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic        clk, reset;
  logic [31:0] InstructionF, PC4F, ResultW;
  logic        StopF, RegWriteE, MemReadE, RegWriteM, RegWriteW;
  logic [4:0]  WriteRegE, WriteRegM, WriteRegW;
  logic        isLWHazard, BubbleD, StopD;
  logic [1:0]  PCSource;
  logic [31:0] PC_B, aD, PC_J, RD1D, RD2D, ImmD;
  logic [4:0]  RsD, RtD, RdD;
  logic [5:0]  OpD, FunctD;

  int total = 0;
  int bad   = 0;

  id_stage dut (
    .clk(clk), .reset(reset), .InstructionF(InstructionF), .PC4F(PC4F), .StopF(StopF),
    .RegWriteE(RegWriteE), .MemReadE(MemReadE), .WriteRegE(WriteRegE),
    .RegWriteM(RegWriteM), .WriteRegM(WriteRegM), .RegWriteW(RegWriteW),
    .WriteRegW(WriteRegW), .ResultW(ResultW), .isLWHazard(isLWHazard),
    .PCSource(PCSource), .PC_B(PC_B), .aD(aD), .PC_J(PC_J), .BubbleD(BubbleD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmD(ImmD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .OpD(OpD), .FunctD(FunctD), .StopD(StopD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_rf [32];
  logic [31:0] m_instr, m_pc4;
  logic        m_stop;
  logic        e_stall;
  logic [1:0]  e_pcs;
  logic [31:0] e_pcb, e_pcj, e_ad, e_rd1, e_rd2, e_imm;

  function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd, input int fn);
    return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(fn);
  endfunction

  function automatic logic [31:0] mk_i(input int op, input int rs, input int rt, input int imm);
    return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | (32'(imm) & 32'h0000_ffff);
  endfunction

  function automatic logic [31:0] mk_j(input int op, input int tgt);
    return (32'(op) << 26) | (32'(tgt) & 32'h03ff_ffff);
  endfunction

  function automatic logic [31:0] cur_instr();
    return {OpD, RsD, RtD, ImmD[15:0]};
  endfunction

  function automatic logic [31:0] m_read(input int r);
    if (r == 0) return 32'h0;
    if (RegWriteW && int'(WriteRegW) == r) return ResultW;
    return m_rf[r];
  endfunction

  function automatic logic m_busy(input int r);
    return (r != 0) && ((RegWriteE && int'(WriteRegE) == r) || (RegWriteM && int'(WriteRegM) == r));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_stop  = 1'b0;
  endtask

  task automatic model_eval();
    int op, rs, rt, fn, imm;
    logic use_rs, use_rt, lu, bd, is_jr;
    op  = int'(m_instr >> 26);
    rs  = int'((m_instr >> 21) % 32);
    rt  = int'((m_instr >> 16) % 32);
    fn  = int'(m_instr % 64);
    imm = int'(m_instr % 65536);
    if (imm >= 32768) imm = imm - 65536;
    use_rs = !(op == 2 || op == 3 || m_instr == 32'hffff_ffff);
    use_rt = (op == 0 || op == 4 || op == 5 || op == 43);
    is_jr  = (op == 0 && fn == 8);
    lu = MemReadE && WriteRegE != 0 &&
         ((use_rs && int'(WriteRegE) == rs) || (use_rt && int'(WriteRegE) == rt));
    bd = ((op == 4 || op == 5 || is_jr) && m_busy(rs)) || ((op == 4 || op == 5) && m_busy(rt));
    e_stall = lu || bd;
    e_rd1 = m_read(rs);
    e_rd2 = m_read(rt);
    e_imm = 32'(imm);
    e_pcb = m_pc4 + 32'(imm);
    e_pcj = (m_pc4 & 32'hfc00_0000) | (m_instr & 32'h03ff_ffff);
    e_ad  = e_rd1;
    e_pcs = 2'd0;
    if (!e_stall && !m_stop) begin
      if ((op == 4 && e_rd1 == e_rd2) || (op == 5 && e_rd1 != e_rd2)) e_pcs = 2'd1;
      else if (op == 2) e_pcs = 2'd3;
      else if (is_jr)   e_pcs = 2'd2;
    end
  endtask

  task automatic model_update();
    if (RegWriteW && WriteRegW != 0) m_rf[WriteRegW] = ResultW;
    if (!e_stall) begin
      m_stop  = m_stop | StopF;
      m_instr = (e_pcs != 0) ? 32'h0 : InstructionF;
      m_pc4   = PC4F;
    end
  endtask

  // One clock edge with the model advanced alongside the DUT.
  task automatic step();
    model_eval();
    @(posedge clk);
    if (!reset) model_reset();
    else        model_update();
    #1;
  endtask

  task automatic idle();
    InstructionF = 32'h0; PC4F = 32'h0; StopF = 1'b0;
    RegWriteE = 1'b0; MemReadE = 1'b0; WriteRegE = 5'd0;
    RegWriteM = 1'b0; WriteRegM = 5'd0;
    RegWriteW = 1'b0; WriteRegW = 5'd0; ResultW = 32'h0;
  endtask

  task automatic load_instr(input logic [31:0] i, input logic [31:0] p);
    InstructionF = i; PC4F = p; #1;
    step();
    InstructionF = 32'h0; PC4F = 32'h0;
  endtask

  task automatic wr(input int r, input logic [31:0] v);
    RegWriteW = 1'b1; WriteRegW = 5'(r); ResultW = v; #1;
    step();
    RegWriteW = 1'b0; WriteRegW = 5'd0; ResultW = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    reset = 1'b0;
    model_reset();
    #3;
    total++; if (PCSource !== 2'b00 || isLWHazard !== 1'b0 || BubbleD !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl pcs=%b haz=%b bub=%b want 00/0/0", PCSource, isLWHazard, BubbleD); end
    total++; if (PC_B !== 32'h0 || PC_J !== 32'h0 || aD !== 32'h0) begin
      bad++; $display("FAIL reset_tgt pcb=%h pcj=%h ad=%h want 0", PC_B, PC_J, aD); end
    total++; if (cur_instr() !== 32'h0 || StopD !== 1'b0) begin
      bad++; $display("FAIL reset_ifid instr=%h stop=%b want 0/0", cur_instr(), StopD); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_writethrough();
    load_instr(mk_r(5, 6, 7, 32), 32'h4);
    RegWriteW = 1'b1; WriteRegW = 5'd5; ResultW = 32'h1234; #1;
    total++; if (RD1D !== 32'h1234) begin
      bad++; $display("FAIL wt_bypass rd1=%h want 00001234", RD1D); end
    step();
    WriteRegW = 5'd0; ResultW = 32'hffff;
    InstructionF = mk_r(0, 5, 1, 32); #1;
    step();
    InstructionF = 32'h0;
    total++; if (RD1D !== 32'h0 || RD2D !== 32'h1234) begin
      bad++; $display("FAIL wt_r0 rd1=%h rd2=%h want 0/00001234", RD1D, RD2D); end
    RegWriteW = 1'b0; WriteRegW = 5'd0; ResultW = 32'h0;
  endtask

  task automatic test_load_use();
    load_instr(mk_r(3, 8, 9, 32), 32'h4);
    MemReadE = 1'b1; WriteRegE = 5'd8;
    InstructionF = mk_r(1, 2, 3, 32); PC4F = 32'h8; #1;
    total++; if (isLWHazard !== 1'b1 || BubbleD !== 1'b1 || PCSource !== 2'b00) begin
      bad++; $display("FAIL lu_stall haz=%b bub=%b pcs=%b want 1/1/00", isLWHazard, BubbleD, PCSource); end
    step();
    total++; if (RsD !== 5'd3 || RtD !== 5'd8) begin
      bad++; $display("FAIL lu_hold rs=%0d rt=%0d want 3/8", RsD, RtD); end
    MemReadE = 1'b0; #1;
    total++; if (isLWHazard !== 1'b0) begin
      bad++; $display("FAIL lu_clear haz=%b want 0", isLWHazard); end
    step();
    total++; if (RsD !== 5'd1 || RtD !== 5'd2) begin
      bad++; $display("FAIL lu_advance rs=%0d rt=%0d want 1/2", RsD, RtD); end
    idle();
  endtask

  task automatic test_beq();
    wr(1, 32'd7);
    wr(2, 32'd7);
    load_instr(mk_i(4, 1, 2, 3), 32'h10);
    #1;
    total++; if (PCSource !== 2'b01 || PC_B !== 32'h13) begin
      bad++; $display("FAIL beq_taken pcs=%b pcb=%h want 01/00000013", PCSource, PC_B); end
    InstructionF = mk_r(1, 2, 3, 32); #1;
    step();
    InstructionF = 32'h0;
    total++; if (cur_instr() !== 32'h0) begin
      bad++; $display("FAIL beq_flush instr=%h want 0", cur_instr()); end
    wr(2, 32'd8);
    load_instr(mk_i(4, 1, 2, 3), 32'h10);
    #1;
    total++; if (PCSource !== 2'b00) begin
      bad++; $display("FAIL beq_not_taken pcs=%b want 00", PCSource); end
    load_instr(32'h0, 32'h0);
  endtask

  task automatic test_branch_hazard();
    wr(2, 32'd7);
    load_instr(mk_i(4, 1, 2, 3), 32'h10);
    RegWriteM = 1'b1; WriteRegM = 5'd1; #1;
    total++; if (isLWHazard !== 1'b1 || PCSource !== 2'b00) begin
      bad++; $display("FAIL bh_mem haz=%b pcs=%b want 1/00", isLWHazard, PCSource); end
    step();
    total++; if (OpD !== 6'd4 || RsD !== 5'd1 || RtD !== 5'd2) begin
      bad++; $display("FAIL bh_hold op=%0d rs=%0d rt=%0d want 4/1/2", OpD, RsD, RtD); end
    RegWriteM = 1'b0; WriteRegM = 5'd0; #1;
    total++; if (isLWHazard !== 1'b0 || PCSource !== 2'b01) begin
      bad++; $display("FAIL bh_resolve haz=%b pcs=%b want 0/01", isLWHazard, PCSource); end
    step();
    load_instr(mk_i(5, 1, 2, 3), 32'h20);
    RegWriteE = 1'b1; WriteRegE = 5'd2; #1;
    total++; if (isLWHazard !== 1'b1 || PCSource !== 2'b00) begin
      bad++; $display("FAIL bh_ex haz=%b pcs=%b want 1/00", isLWHazard, PCSource); end
    RegWriteE = 1'b0; WriteRegE = 5'd0; #1;
    total++; if (PCSource !== 2'b00) begin
      bad++; $display("FAIL bne_equal pcs=%b want 00", PCSource); end
    step();
  endtask

  task automatic test_jumps();
    wr(31, 32'h40);
    load_instr(mk_r(31, 0, 0, 8), 32'h20);
    #1;
    total++; if (PCSource !== 2'b10 || aD !== 32'h40) begin
      bad++; $display("FAIL jr pcs=%b ad=%h want 10/00000040", PCSource, aD); end
    InstructionF = mk_r(1, 2, 3, 32); #1;
    step();
    InstructionF = 32'h0;
    total++; if (cur_instr() !== 32'h0) begin
      bad++; $display("FAIL jr_flush instr=%h want 0", cur_instr()); end
    load_instr(mk_j(2, 32'h123), 32'h8000_0010);
    #1;
    total++; if (PCSource !== 2'b11 || PC_J !== 32'h8000_0123) begin
      bad++; $display("FAIL j pcs=%b pcj=%h want 11/80000123", PCSource, PC_J); end
    step();
  endtask

  task automatic test_stop();
    StopF = 1'b1; #1;
    step();
    StopF = 1'b0;
    load_instr(mk_j(2, 32'h5), 32'h4);
    #1;
    total++; if (StopD !== 1'b1 || PCSource !== 2'b00) begin
      bad++; $display("FAIL stop_sticky stop=%b pcs=%b want 1/00", StopD, PCSource); end
    do_reset();
    total++; if (StopD !== 1'b0) begin
      bad++; $display("FAIL stop_reset stop=%b want 0", StopD); end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1: ins = mk_r(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 32);
        2:    ins = mk_i(4, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom));
        3:    ins = mk_i(5, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom));
        4:    ins = mk_j(2, int'($urandom));
        5:    ins = mk_r(int'($urandom_range(0, 7)), 0, 0, 8);
        6:    ins = mk_i(35, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom));
        7:    ins = mk_i(43, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom));
        8:    ins = 32'hffff_ffff;
        default: ins = $urandom;
      endcase
      InstructionF = ins;
      PC4F      = $urandom;
      RegWriteE = 1'($urandom_range(0, 1));
      MemReadE  = ($urandom_range(0, 3) == 0);
      WriteRegE = 5'($urandom_range(0, 7));
      RegWriteM = ($urandom_range(0, 2) == 0);
      WriteRegM = 5'($urandom_range(0, 7));
      RegWriteW = 1'($urandom_range(0, 1));
      WriteRegW = 5'($urandom_range(0, 7));
      ResultW   = 32'($urandom_range(0, 3));
      #1;
      model_eval();
      total++; if (isLWHazard !== e_stall || BubbleD !== e_stall) begin
        bad++; $display("FAIL rnd_stall n=%0d haz=%b bub=%b want %b", n, isLWHazard, BubbleD, e_stall); end
      total++; if (PCSource !== e_pcs) begin
        bad++; $display("FAIL rnd_pcs n=%0d pcs=%b want %b", n, PCSource, e_pcs); end
      total++; if (RD1D !== e_rd1 || RD2D !== e_rd2) begin
        bad++; $display("FAIL rnd_read n=%0d rd1=%h rd2=%h want %h/%h", n, RD1D, RD2D, e_rd1, e_rd2); end
      total++; if (PC_B !== e_pcb || PC_J !== e_pcj || aD !== e_ad) begin
        bad++; $display("FAIL rnd_tgt n=%0d pcb=%h pcj=%h ad=%h want %h/%h/%h", n, PC_B, PC_J, aD, e_pcb, e_pcj, e_ad); end
      total++; if (cur_instr() !== m_instr || ImmD !== e_imm || RdD !== 5'((m_instr >> 11) % 32) ||
                   FunctD !== 6'(m_instr % 64)) begin
        bad++; $display("FAIL rnd_fields n=%0d instr=%h imm=%h want %h/%h", n, cur_instr(), ImmD, m_instr, e_imm); end
      step();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    #1;
    step();
    wr(4, 32'h55);
    load_instr(mk_r(4, 8, 1, 32), 32'h0);
    MemReadE = 1'b1; WriteRegE = 5'd8; #1;
    step();
    total++; if (isLWHazard !== 1'b1) begin
      bad++; $display("FAIL rm_stall haz=%b want 1", isLWHazard); end
    #1;
    reset = 1'b0;
    #1;
    total++; if (cur_instr() !== 32'h0 || PCSource !== 2'b00 || isLWHazard !== 1'b0 || BubbleD !== 1'b0) begin
      bad++; $display("FAIL rm_clear instr=%h pcs=%b haz=%b bub=%b want 0", cur_instr(), PCSource, isLWHazard, BubbleD); end
    total++; if (RD1D !== 32'h0 || RD2D !== 32'h0) begin
      bad++; $display("FAIL rm_regs rd1=%h rd2=%h want 0", RD1D, RD2D); end
    model_reset();
    idle();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++; if (RD1D !== 32'h0) begin
      bad++; $display("FAIL rm_after rd1=%h want 0", RD1D); end
  endtask

  initial begin
    test_reset();
    test_writethrough();
    test_load_use();
    test_beq();
    test_branch_hazard();
    test_jumps();
    test_stop();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
